word_serializer_ctrl: RTL and testbench
=======================================

Name: word_serializer_ctrl

Overview:
- Sequencing controller for the 16-to-8 shift register (shiftreg16to8) in the serial transmit path.
- Arbitrates round-robin between NUM_REQ word producers and hands the granted 16-bit word to the shift register with a one-cycle load.
- Presents the two resulting bytes, low byte first, to a downstream byte consumer over a valid/ready handshake, driving shift_enable between them.

Parameters:
- NUM_REQ, 2, number of word requesters (1..8).
- GRANT_W, $clog2(NUM_REQ) clamped to minimum 1, width of grant index (derived, not overridden).

Ports:
- clk2  input  1  system clock; all state updates on rising edge.
- NReset  input  1  reset, synchronous, active-low; same net also drives the shift register's reset.
- req  input  NUM_REQ  per-requester word request; held high until matching ack.
- req_word  input  16*NUM_REQ  flattened words; requester i occupies [16*i+15:16*i].
- req_ack  output  NUM_REQ  one-cycle pulse: word of requester i accepted.
- load_enable  output  1  to shift register: load sixteenbits this edge.
- shift_enable  output  1  to shift register: shift right by 8 this edge.
- sixteenbits  output  16  word to shift register (granted req_word).
- eightbits  input  1x8  current low byte from shift register.
- byte_out  output  8  byte to consumer (eightbits forwarded combinationally).
- byte_valid  output  1  byte_out valid.
- byte_last  output  1  high with byte_valid on the high (second) byte.
- byte_ready  input  1  consumer accepts byte when byte_valid && byte_ready.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  GRANT_W  index of requester currently being serialized.

Behaviour:
- States (Moore except load/ack): IDLE, SEND_LO, SEND_HI.
- Reset (NReset low at clk2 edge):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first; grant_id=0.
  - All outputs 0 except byte_out, which follows eightbits; the shift register clears at the same time.
- Reset mid-operation: the word in flight is dropped, no ack is re-issued, and the consumer sees byte_valid fall.
- IDLE, any req set:
  - Winner = first set bit searching upward from last_grant+1, wrapping at NUM_REQ.
  - Same cycle: load_enable=1, sixteenbits=req_word[winner], req_ack[winner]=1.
  - Next edge: grant_id and last_grant take winner; state -> SEND_LO.
- IDLE, no req: load_enable=0, sixteenbits=0, stay.
- SEND_LO: byte_valid=1, byte_last=0.
  - On byte_ready: shift_enable=1 in the same cycle, state -> SEND_HI.
  - Else hold; byte_out stays stable.
- SEND_HI: byte_valid=1, byte_last=1.
  - On byte_ready: state -> IDLE (see optional feature). No shift is issued; the register is overwritten at the next load.
- Latency: req rising in IDLE -> first byte_valid 1 cycle later.
- Throughput without the optional feature: 3 cycles per word with byte_ready constantly high.
- load_enable and shift_enable are never high in the same cycle.
- Requests arriving while busy wait; req lowered before ack is simply not served.
- Simultaneous requests: exactly one ack per load, fairness by rotation.

Optional Feature:
- Macro SERCTRL_B2B_EN.
- Defined: in SEND_HI, when byte_ready && any req, arbitrate as in IDLE in that same cycle: load_enable=1, req_ack pulse, state -> SEND_LO. This gives 2 cycles per word. Otherwise SEND_HI -> IDLE.
- Undefined: SEND_HI always returns to IDLE, giving one idle cycle between words.

Decomposition:
- serctrl_pkg:
  - state enum (IDLE, SEND_LO, SEND_HI).
  - BYTE_W=8, WORD_W=16.
- Sub-module rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req, last_grant. Outputs: any_req, winner index, one-hot grant.
  - Combinational; the last_grant register stays in the controller.

Test Plan:
- Reset then req=2'b01, req_word[15:0]=16'hA55A, byte_ready=1:
  - req_ack=01 and load in cycle 0.
  - bytes 8'h5A (last=0) then 8'hA5 (last=1).
  - busy falls after 3 cycles.
- Both req high, words 16'h1122 and 16'h3344:
  - grants 0 then 1.
  - byte stream 22,11,44,33.
  - with both held for 2 more words, grants alternate 0,1,0,1.
- byte_ready low 4 cycles in SEND_LO, then in SEND_HI:
  - byte_out and byte_valid stable.
  - no shift_enable until the handshake.
  - exactly 2 accepted bytes.
- NReset low for 1 cycle while in SEND_HI:
  - next cycle IDLE, all outputs 0, no ack.
  - pending req re-granted from index 0.
- With SERCTRL_B2B_EN and req=01 held, byte_ready=1:
  - back-to-back loads every 2 cycles, no IDLE cycle.
  - without the macro, a 1-cycle gap between words.
- NUM_REQ=3, req=3'b101 after last grant 2:
  - grant 0, then 2, then 0.

Source files
------------

// File: rtl/serctrl_pkg.sv
// Shared types and widths for the word serializer controller.
// Optional back-to-back word loading is enabled with SERCTRL_B2B_EN.
package serctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;

    // Grant index width; a single requester still needs one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above
// last_grant and wraps; the caller owns the last_grant register.
module rr_arbiter
    import serctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               any_req,
    output logic [GRANT_W-1:0] winner,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    always_comb begin
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        // Upper half of the ring first, then wrap to index 0.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j > int'(last_grant))) begin
                found  = 1'b1;
                winner = GRANT_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = GRANT_W'(j);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = found && (winner == GRANT_W'(j));
        end
    end

endmodule

// File: rtl/word_serializer_ctrl.sv
// Loads granted words into the 16-to-8 shift register and streams
// both bytes low-first; SERCTRL_B2B_EN allows reload from SEND_HI.
module word_serializer_ctrl
    import serctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic                      clk2,
    input  logic                      NReset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [WORD_W*NUM_REQ-1:0] req_word,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      load_enable,
    output logic                      shift_enable,
    output logic [WORD_W-1:0]         sixteenbits,
    input  logic [BYTE_W-1:0]         eightbits,
    output logic [BYTE_W-1:0]         byte_out,
    output logic                      byte_valid,
    output logic                      byte_last,
    input  logic                      byte_ready,
    output logic                      busy,
    output logic [GRANT_W-1:0]        grant_id
);

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;

    logic                 any_req;
    logic [GRANT_W-1:0]   winner;
    logic [NUM_REQ-1:0]   grant;
    logic [WORD_W-1:0]    word_sel;
    logic                 hi_reload;
    logic                 load;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .winner     (winner),
        .grant      (grant)
    );

    always_comb begin
        word_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                word_sel = req_word[j*WORD_W +: WORD_W];
            end
        end
    end

`ifdef SERCTRL_B2B_EN
    assign hi_reload = (state_q == SEND_HI) && byte_ready;
`else
    assign hi_reload = 1'b0;
`endif

    // Held off during reset so no word is acked and then dropped.
    assign load = NReset && any_req &&
                  ((state_q == IDLE) || hi_reload);

    always_ff @(posedge clk2) begin
        if (!NReset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (byte_ready) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (byte_ready) begin
                    state_d = load ? SEND_LO : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            last_grant_d = winner;
            grant_id_d   = winner;
        end
    end

    always_comb begin
        req_ack      = '0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        sixteenbits  = '0;
        byte_out     = eightbits;
        byte_valid   = 1'b0;
        byte_last    = 1'b0;
        busy         = 1'b0;
        grant_id     = '0;
        if (NReset) begin
            load_enable = load;
            req_ack     = load ? grant : '0;
            sixteenbits = load ? word_sel : '0;
            busy        = (state_q != IDLE);
            grant_id    = grant_id_q;
            unique case (state_q)
                SEND_LO: begin
                    byte_valid   = 1'b1;
                    shift_enable = byte_ready;
                end
                SEND_HI: begin
                    byte_valid = 1'b1;
                    byte_last  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer_ctrl.sv
// Self-checking bench for word_serializer_ctrl: vector table, directed
// corner sequences and a randomized run against a transaction model.
module tb_word_serializer_ctrl;

`ifdef SERCTRL_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk2 = 1'b0;
    logic        NReset;
    logic [1:0]  req;
    logic [31:0] req_word;
    logic [1:0]  req_ack;
    logic        load_enable, shift_enable;
    logic [15:0] sixteenbits;
    logic [7:0]  eightbits, byte_out;
    logic        byte_valid, byte_last, byte_ready, busy;
    logic [0:0]  grant_id;

    logic [2:0]  req3;
    logic [47:0] req_word3;
    logic [2:0]  req_ack3;
    logic        load3, shift3, valid3, last3, ready3, busy3;
    logic [15:0] six3;
    logic [7:0]  eight3, bout3;
    logic [1:0]  gid3;

    logic [15:0] sr_q;

    int checks = 0;
    int failures = 0;

    always #5 clk2 = ~clk2;

    word_serializer_ctrl #(.NUM_REQ(2)) u_dut (
        .clk2(clk2), .NReset(NReset), .req(req), .req_word(req_word),
        .req_ack(req_ack), .load_enable(load_enable),
        .shift_enable(shift_enable), .sixteenbits(sixteenbits),
        .eightbits(eightbits), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .busy(busy), .grant_id(grant_id)
    );

    word_serializer_ctrl #(.NUM_REQ(3)) u_dut3 (
        .clk2(clk2), .NReset(NReset), .req(req3), .req_word(req_word3),
        .req_ack(req_ack3), .load_enable(load3),
        .shift_enable(shift3), .sixteenbits(six3),
        .eightbits(eight3), .byte_out(bout3),
        .byte_valid(valid3), .byte_last(last3),
        .byte_ready(ready3), .busy(busy3), .grant_id(gid3)
    );

    // Behavioural stand-in for the external 16-to-8 shift register.
    always @(posedge clk2) begin
        if (!NReset)           sr_q <= 16'h0000;
        else if (load_enable)  sr_q <= sixteenbits;
        else if (shift_enable) sr_q <= sr_q >> 8;
    end
    assign eightbits = sr_q[7:0];
    assign eight3    = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic rst_cycle();
        NReset = 1'b0;
        req    = 2'b00;
        req3   = 3'b000;
        tick();
        NReset = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk(nm, busy, 0);
    endtask

    typedef struct {
        logic        rst_n;
        logic [1:0]  req;
        logic        ready;
        logic [1:0]  ack;
        logic        load;
        logic        shift;
        logic [15:0] six;
        logic        valid;
        logic        last;
        logic [7:0]  bout;
        logic        busy;
        logic        gid;
    } vec_t;

    vec_t tv[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  acks[$];
        logic [7:0]  bytes[$];
        logic [7:0]  eb[8];
        logic [2:0]  acks3[$];
        int          loads[$];
        int          hs;

        tv[0]  = '{1, 2'b01, 1, 2'b01, 1, 0, 16'hA55A, 0, 0, 8'h00, 0, 0};
        tv[1]  = '{1, 2'b00, 1, 2'b00, 0, 1, 16'h0000, 1, 0, 8'h5A, 1, 0};
        tv[2]  = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 1, 1, 8'hA5, 1, 0};
        tv[3]  = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 0, 0, 8'hA5, 0, 0};
        tv[4]  = '{1, 2'b10, 1, 2'b10, 1, 0, 16'h3344, 0, 0, 8'hA5, 0, 0};
        tv[5]  = '{1, 2'b00, 0, 2'b00, 0, 0, 16'h0000, 1, 0, 8'h44, 1, 1};
        tv[6]  = '{1, 2'b00, 1, 2'b00, 0, 1, 16'h0000, 1, 0, 8'h44, 1, 1};
        tv[7]  = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 1, 1, 8'h33, 1, 1};
        tv[8]  = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 0, 0, 8'h33, 0, 1};
        tv[9]  = '{0, 2'b11, 1, 2'b00, 0, 0, 16'h0000, 0, 0, 8'h33, 0, 0};
        tv[10] = '{1, 2'b11, 1, 2'b01, 1, 0, 16'hA55A, 0, 0, 8'h00, 0, 0};
        tv[11] = '{1, 2'b00, 1, 2'b00, 0, 1, 16'h0000, 1, 0, 8'h5A, 1, 0};
        tv[12] = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 1, 1, 8'hA5, 1, 0};
        tv[13] = '{1, 2'b00, 1, 2'b00, 0, 0, 16'h0000, 0, 0, 8'hA5, 0, 0};

        NReset     = 1'b0;
        req        = 2'b00;
        req_word   = 32'h0;
        byte_ready = 1'b0;
        req3       = 3'b000;
        req_word3  = 48'h0;
        ready3     = 1'b0;

        // Reset state
        tick();
        @(negedge clk2);
        chk("rst_ack", req_ack, 0);
        chk("rst_load", load_enable, 0);
        chk("rst_shift", shift_enable, 0);
        chk("rst_six", sixteenbits, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_last", byte_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_byte", byte_out, 8'h00);
        tick();
        NReset = 1'b1;
        @(negedge clk2);
        chk("idle_load", load_enable, 0);
        chk("idle_six", sixteenbits, 0);
        chk("idle_busy", busy, 0);
        tick();

        // Cycle-exact vector table
        req_word = {16'h3344, 16'hA55A};
        for (int i = 0; i < 14; i++) begin
            NReset     = tv[i].rst_n;
            req        = tv[i].req;
            byte_ready = tv[i].ready;
            @(negedge clk2);
            chk($sformatf("v%0d_ack", i), req_ack, tv[i].ack);
            chk($sformatf("v%0d_load", i), load_enable, tv[i].load);
            chk($sformatf("v%0d_shift", i), shift_enable, tv[i].shift);
            chk($sformatf("v%0d_six", i), sixteenbits, tv[i].six);
            chk($sformatf("v%0d_valid", i), byte_valid, tv[i].valid);
            chk($sformatf("v%0d_last", i), byte_last, tv[i].last);
            chk($sformatf("v%0d_byte", i), byte_out, tv[i].bout);
            chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d_gid", i), grant_id, tv[i].gid);
            tick();
        end
        NReset = 1'b1;

        // Both requesters held: grants rotate, bytes low-first
        rst_cycle();
        req_word   = {16'h3344, 16'h1122};
        req        = 2'b11;
        byte_ready = 1'b1;
        eb = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44, 8'h33};
        for (int c = 0; c < 40 && bytes.size() < 8; c++) begin
            @(negedge clk2);
            if (req_ack != 2'b00) acks.push_back(req_ack);
            if (byte_valid && byte_ready) bytes.push_back(byte_out);
            tick();
        end
        req = 2'b00;
        chk("rot_nbytes", bytes.size(), 8);
        chk("rot_nacks", (acks.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rot_ack%0d", i),
                (i < acks.size()) ? acks[i] : 2'b00,
                (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rot_byte%0d", i),
                (i < bytes.size()) ? bytes[i] : 8'hxx, eb[i]);
        end
        drain("rot_drain");

        // Consumer stalls in both byte phases
        rst_cycle();
        req_word   = {16'h0000, 16'hBEEF};
        req        = 2'b01;
        byte_ready = 1'b0;
        hs         = 0;
        @(negedge clk2);
        chk("stall_load", load_enable, 1);
        tick();
        req = 2'b00;
        repeat (4) begin
            @(negedge clk2);
            chk("stall_lo_valid", byte_valid, 1);
            chk("stall_lo_last", byte_last, 0);
            chk("stall_lo_byte", byte_out, 8'hEF);
            chk("stall_lo_shift", shift_enable, 0);
            hs += int'(byte_valid && byte_ready);
            tick();
        end
        byte_ready = 1'b1;
        @(negedge clk2);
        chk("stall_lo_hs_shift", shift_enable, 1);
        chk("stall_lo_hs_byte", byte_out, 8'hEF);
        hs += int'(byte_valid && byte_ready);
        tick();
        byte_ready = 1'b0;
        repeat (4) begin
            @(negedge clk2);
            chk("stall_hi_valid", byte_valid, 1);
            chk("stall_hi_last", byte_last, 1);
            chk("stall_hi_byte", byte_out, 8'hBE);
            chk("stall_hi_shift", shift_enable, 0);
            hs += int'(byte_valid && byte_ready);
            tick();
        end
        byte_ready = 1'b1;
        @(negedge clk2);
        chk("stall_hi_hs_last", byte_last, 1);
        chk("stall_hi_hs_shift", shift_enable, 0);
        hs += int'(byte_valid && byte_ready);
        tick();
        @(negedge clk2);
        chk("stall_done_busy", busy, 0);
        hs += int'(byte_valid && byte_ready);
        chk("stall_hs_count", hs, 2);
        tick();

        // Reset while in SEND_HI with requests pending
        rst_cycle();
        req_word   = {16'h3344, 16'h1122};
        req        = 2'b11;
        byte_ready = 1'b1;
        @(negedge clk2);
        chk("mrst_first_ack", req_ack, 2'b01);
        tick();
        req = 2'b10;
        @(negedge clk2);
        chk("mrst_lo_valid", byte_valid, 1);
        tick();
        byte_ready = 1'b0;
        req        = 2'b11;
        @(negedge clk2);
        chk("mrst_hi_last", byte_last, 1);
        tick();
        NReset     = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk2);
        chk("mrst_ack", req_ack, 0);
        chk("mrst_load", load_enable, 0);
        chk("mrst_shift", shift_enable, 0);
        chk("mrst_six", sixteenbits, 0);
        chk("mrst_valid", byte_valid, 0);
        chk("mrst_last", byte_last, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_gid", grant_id, 0);
        tick();
        NReset = 1'b1;
        @(negedge clk2);
        chk("mrst_after_busy", busy, 0);
        chk("mrst_after_valid", byte_valid, 0);
        chk("mrst_after_ack", req_ack, 2'b01);
        chk("mrst_after_six", sixteenbits, 16'h1122);
        tick();
        req = 2'b00;
        drain("mrst_drain");

        // Word-to-word spacing with one requester held high
        rst_cycle();
        req_word   = {16'h0000, 16'h5AA5};
        req        = 2'b01;
        byte_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk2);
            if (load_enable) loads.push_back(c);
            chk("b2b_excl", load_enable && shift_enable, 0);
            tick();
        end
        req = 2'b00;
        chk("b2b_nloads", (loads.size() >= 4) ? 1 : 0, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("b2b_gap%0d", i),
                (i < loads.size()) ? loads[i] - loads[i-1] : 0,
                B2B ? 2 : 3);
        end
        drain("b2b_drain");

        // Three requesters, 3'b101 after reset (last grant 2)
        rst_cycle();
        req_word3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        req3      = 3'b101;
        ready3    = 1'b1;
        for (int c = 0; c < 20 && acks3.size() < 3; c++) begin
            @(negedge clk2);
            if (req_ack3 != 3'b000) begin
                if (acks3.size() == 0) chk("n3_six0", six3, 16'hAAAA);
                acks3.push_back(req_ack3);
            end
            tick();
        end
        req3   = 3'b000;
        ready3 = 1'b0;
        chk("n3_nacks", acks3.size(), 3);
        chk("n3_ack0", (acks3.size() > 0) ? acks3[0] : 3'b000, 3'b001);
        chk("n3_ack1", (acks3.size() > 1) ? acks3[1] : 3'b000, 3'b100);
        chk("n3_ack2", (acks3.size() > 2) ? acks3[2] : 3'b000, 3'b001);

        // Randomized run against a transaction-level model
        rst_cycle();
        req        = 2'b00;
        byte_ready = 1'b1;
        begin
            int          pend;
            int          lg;
            int          gid;
            int          w;
            bit          found;
            bit          exp_load;
            logic [1:0]  ackd;
            logic [15:0] wd;
            logic [7:0]  bq[$];
            pend = 0;
            lg   = 1;
            gid  = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk2);
                found = 1'b0;
                w     = 0;
                for (int k = 1; k <= 2; k++) begin
                    if (!found && req[(lg + k) % 2]) begin
                        found = 1'b1;
                        w     = (lg + k) % 2;
                    end
                end
                exp_load = found &&
                    (pend == 0 || (B2B && pend == 1 && byte_ready));
                wd = req_word[16*w +: 16];
                chk("r_load", load_enable, exp_load);
                chk("r_ack", req_ack, exp_load ? (2'b01 << w) : 2'b00);
                chk("r_six", sixteenbits, exp_load ? wd : 16'h0);
                chk("r_shift", shift_enable, pend == 2 && byte_ready);
                chk("r_valid", byte_valid, pend > 0);
                chk("r_last", byte_last, pend == 1);
                chk("r_busy", busy, pend > 0);
                chk("r_gid", grant_id, gid);
                if (pend > 0) chk("r_byte", byte_out, bq[0]);
                if (pend > 0 && byte_ready) begin
                    void'(bq.pop_front());
                    pend--;
                end
                ackd = 2'b00;
                if (exp_load) begin
                    bq.push_back(wd[7:0]);
                    bq.push_back(wd[15:8]);
                    pend += 2;
                    lg   = w;
                    gid  = w;
                    ackd = 2'b01 << w;
                end
                tick();
                for (int i = 0; i < 2; i++) begin
                    if (ackd[i]) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        req_word[16*i +: 16] = 16'($urandom);
                    end
                end
                byte_ready = ($urandom_range(3) != 0);
            end
        end
        req        = 2'b00;
        byte_ready = 1'b1;
        drain("r_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
